// File: rtl/bbq_out_buffer_if.sv
// Bundle of the controller-facing and egress-facing signals of bbq_out_buffer.
//   slave  : view used by bbq_out_buffer (takes deq_en/in_*/out_ready, drives the rest)
//   master : view used by the surrounding controller/consumer environment
interface bbq_out_buffer_if #(
  parameter int unsigned HEAP_ENTRY_DWIDTH = 32,
  parameter int unsigned OUT_BUFF_SIZE     = 16,
  parameter int unsigned MAX_INFLIGHT      = 4
);
  localparam int unsigned CNT_W = $clog2(OUT_BUFF_SIZE + 1);
  localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);

  logic                         deq_en;
  logic                         deq_req;
  logic                         in_valid;
  logic [HEAP_ENTRY_DWIDTH-1:0] in_buff_addr;
  logic                         in_empty;
  logic                         out_valid;
  logic                         out_ready;
  logic [HEAP_ENTRY_DWIDTH-1:0] out_buff_addr;
  logic [CNT_W-1:0]             count;
  logic [INF_W-1:0]             inflight;
  logic                         err;

  modport slave (
    input  deq_en, in_valid, in_buff_addr, in_empty, out_ready,
    output deq_req, out_valid, out_buff_addr, count, inflight, err
  );

  modport master (
    output deq_en, in_valid, in_buff_addr, in_empty, out_ready,
    input  deq_req, out_valid, out_buff_addr, count, inflight, err
  );
endinterface

// File: rtl/bbq_out_buffer.sv
// Output buffer behind the BBQ controller. Issues dequeue requests only when
// FIFO space is already reserved for every outstanding response, buffers the
// returned addresses and presents them first-word-fall-through to the consumer.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - bbq_out_buffer_if.slave: deq_en/deq_req request pacing,
//          in_valid/in_empty/in_buff_addr controller response,
//          out_valid/out_ready/out_buff_addr egress handshake,
//          count/inflight status, sticky err flag
module bbq_out_buffer #(
  parameter int unsigned HEAP_ENTRY_DWIDTH = 32,
  parameter int unsigned OUT_BUFF_SIZE     = 16,
  parameter int unsigned MAX_INFLIGHT      = 4
) (
  input  logic            clk,
  input  logic            rst,
  bbq_out_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(OUT_BUFF_SIZE);
  localparam int unsigned CNT_W = $clog2(OUT_BUFF_SIZE + 1);
  localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);

  logic [HEAP_ENTRY_DWIDTH-1:0] mem_q [OUT_BUFF_SIZE];

  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic             err_q,      err_d;

  logic req_c;
  logic resp_c;
  logic pop_c;
  logic full_c;
  logic wr_en_c;

  // Request pacing: space for all outstanding responses plus this one must exist.
  always_comb begin
    req_c = 1'b0;
    if (rst && bus.deq_en &&
        (32'(inflight_q) < MAX_INFLIGHT) &&
        ((32'(count_q) + 32'(inflight_q)) < OUT_BUFF_SIZE)) begin
      req_c = 1'b1;
    end
  end

  // Datapath qualifiers; a write into a full FIFO is allowed only alongside a pop.
  always_comb begin
    resp_c  = bus.in_valid | bus.in_empty;
    full_c  = (32'(count_q) == OUT_BUFF_SIZE);
    pop_c   = (count_q != '0) && bus.out_ready;
    wr_en_c = bus.in_valid && (!full_c || pop_c);
  end

  // Next-state for pointers, occupancy, outstanding requests and error flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    err_d      = err_q;

    if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)   rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({wr_en_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A response with nothing outstanding is not counted, so inflight never wraps.
    if (req_c && !resp_c) begin
      inflight_d = inflight_q + INF_W'(1);
    end else if (!req_c && resp_c && (inflight_q != '0)) begin
      inflight_d = inflight_q - INF_W'(1);
    end

    if (resp_c && (inflight_q == '0))   err_d = 1'b1;
    if (bus.in_valid && bus.in_empty)   err_d = 1'b1;
    if (bus.in_valid && !wr_en_c)       err_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= bus.in_buff_addr;
  end

  // Head is forced to zero while empty so stale storage never leaks out.
  assign bus.deq_req       = req_c;
  assign bus.out_valid     = (count_q != '0);
  assign bus.out_buff_addr = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.count         = count_q;
  assign bus.inflight      = inflight_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_bbq_out_buffer.sv
// Self-checking bench for bbq_out_buffer: constant vector table, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_bbq_out_buffer;
  localparam int unsigned DW   = 32;
  localparam int unsigned SIZE = 16;
  localparam int unsigned MAXI = 4;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bbq_out_buffer_if #(.HEAP_ENTRY_DWIDTH(DW), .OUT_BUFF_SIZE(SIZE), .MAX_INFLIGHT(MAXI)) bus ();

  bbq_out_buffer #(.HEAP_ENTRY_DWIDTH(DW), .OUT_BUFF_SIZE(SIZE), .MAX_INFLIGHT(MAXI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: FIFO contents as a queue, outstanding count and sticky error.
  logic [DW-1:0] mq[$];
  int            m_inf;
  bit            m_err;
  bit            m_req;
  bit            seen_req;

  // Controller model: due cycles of outstanding requests, in order.
  int            cyc;
  int            pend[$];
  int            last_due;
  logic [DW-1:0] next_addr;

  typedef struct {
    bit          en;
    bit          v;
    bit          e;
    logic [31:0] a;
    bit          rdy;
    bit          x_req;
    int          x_cnt;
    int          x_inf;
    bit          x_val;
    logic [31:0] x_addr;
    bit          x_err;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_req(input bit en);
    return rst && en && (m_inf < int'(MAXI)) && ((mq.size() + m_inf) < int'(SIZE));
  endfunction

  task automatic check_state();
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("out_buff_addr", bus.out_buff_addr, (mq.size() != 0) ? mq[0] : '0);
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("inflight", 32'(bus.inflight), 32'(m_inf));
    chk("err", 32'(bus.err), 32'(m_err));
  endtask

  // One clock: check state, drive inputs, check deq_req, advance the model.
  task automatic cycle(input bit en, input bit v, input bit e, input logic [DW-1:0] a, input bit rdy);
    bit pop;
    bit resp;
    check_state();
    bus.deq_en       = en;
    bus.in_valid     = v;
    bus.in_empty     = e;
    bus.in_buff_addr = a;
    bus.out_ready    = rdy;
    #1;
    m_req    = model_req(en);
    seen_req = bus.deq_req;
    chk("deq_req", 32'(seen_req), 32'(m_req));
    pop  = (mq.size() != 0) && rdy;
    resp = v || e;
    if (resp && m_inf == 0) m_err = 1'b1;
    if (v && e) m_err = 1'b1;
    if (pop) void'(mq.pop_front());
    if (v) begin
      if (mq.size() < int'(SIZE)) mq.push_back(a);
      else m_err = 1'b1;
    end
    m_inf = m_inf + int'(m_req) - int'(resp);
    if (m_inf < 0) m_inf = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Controller answers each request in order after lat_lo..lat_hi cycles.
  task automatic ctrl_step(input bit en, input bit rdy, input int lat_lo, input int lat_hi,
                           input int empty_pct, input int spur_pct);
    bit            v;
    bit            e;
    logic [DW-1:0] a;
    int            due;
    v = 1'b0;
    e = 1'b0;
    a = '0;
    if (pend.size() != 0 && pend[0] <= cyc) begin
      void'(pend.pop_front());
      if (int'($urandom_range(99)) < empty_pct) e = 1'b1;
      else begin
        v = 1'b1;
        a = next_addr;
        next_addr = next_addr + 32'd4;
      end
    end else if (spur_pct != 0 && int'($urandom_range(99)) < spur_pct) begin
      v = 1'b1;
      a = $urandom;
    end
    cycle(en, v, e, a, rdy);
    if (m_req) begin
      due = (cyc - 1) + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back(due);
    end
  endtask

  task automatic clear_ctrl();
    pend.delete();
    last_due = cyc;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input bit en);
    bus.deq_en       = en;
    bus.in_valid     = 1'b0;
    bus.in_empty     = 1'b0;
    bus.in_buff_addr = '0;
    bus.out_ready    = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_inflight", 32'(bus.inflight), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_deq_req", 32'(bus.deq_req), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_out_buff_addr", bus.out_buff_addr, 32'd0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    m_inf = 0;
    m_err = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bias;
    rst              = 1'b0;
    bus.deq_en       = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_empty     = 1'b0;
    bus.in_buff_addr = '0;
    bus.out_ready    = 1'b0;
    cyc       = 0;
    last_due  = 0;
    m_inf     = 0;
    m_err     = 1'b0;
    next_addr = 32'h100;

    //          en v  e  addr      rdy  req cnt inf val addr      err
    tbl[0] = '{1, 0, 0, 32'h0,    0,   1,  0,  1,  0,  32'h0,    0};
    tbl[1] = '{1, 1, 0, 32'h10,   0,   1,  1,  1,  1,  32'h10,   0};
    tbl[2] = '{0, 1, 0, 32'h20,   1,   0,  1,  0,  1,  32'h20,   0};
    tbl[3] = '{0, 0, 1, 32'h0,    0,   0,  1,  0,  1,  32'h20,   1};
    tbl[4] = '{0, 1, 1, 32'h30,   0,   0,  2,  0,  1,  32'h20,   1};
    tbl[5] = '{0, 0, 0, 32'h0,    1,   0,  1,  0,  1,  32'h30,   1};
    tbl[6] = '{0, 0, 0, 32'h0,    1,   0,  0,  0,  0,  32'h0,    1};
    tbl[7] = '{1, 0, 0, 32'h0,    1,   1,  0,  1,  0,  32'h0,    1};
    tbl[8] = '{1, 0, 1, 32'h0,    1,   1,  0,  1,  0,  32'h0,    1};

    @(negedge clk);
    do_reset(1'b1);

    // Constant vector table.
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].en, tbl[i].v, tbl[i].e, tbl[i].a, tbl[i].rdy);
      chk($sformatf("tbl%0d_req", i), 32'(seen_req), 32'(tbl[i].x_req));
      chk($sformatf("tbl%0d_count", i), 32'(bus.count), 32'(tbl[i].x_cnt));
      chk($sformatf("tbl%0d_inflight", i), 32'(bus.inflight), 32'(tbl[i].x_inf));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].x_val));
      chk($sformatf("tbl%0d_addr", i), bus.out_buff_addr, tbl[i].x_addr);
      chk($sformatf("tbl%0d_err", i), 32'(bus.err), 32'(tbl[i].x_err));
    end

    // Streaming with 2-cycle controller latency.
    do_reset(1'b1);
    clear_ctrl();
    next_addr = 32'h100;
    for (int i = 0; i < 40; i++) ctrl_step(1'b1, 1'b1, 2, 2, 0, 0);
    chk("stream_inflight", 32'(bus.inflight), 32'd2);
    chk("stream_err", 32'(bus.err), 32'd0);

    // Fill to capacity under backpressure, overflow, full write+pop, drain.
    do_reset(1'b1);
    clear_ctrl();
    next_addr = 32'h1000;
    for (int i = 0; i < 60; i++) ctrl_step(1'b1, 1'b0, 3, 3, 0, 0);
    chk("fill_count", 32'(bus.count), 32'd16);
    chk("fill_inflight", 32'(bus.inflight), 32'd0);
    chk("fill_deq_req", 32'(bus.deq_req), 32'd0);
    chk("fill_err", 32'(bus.err), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'hDEAD, 1'b0);
    chk("overflow_count", 32'(bus.count), 32'd16);
    chk("overflow_err", 32'(bus.err), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 32'hBEEF, 1'b1);
    chk("full_wr_pop_count", 32'(bus.count), 32'd16);
    chk("full_wr_pop_head", bus.out_buff_addr, 32'h1004);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("drain_count", 32'(bus.count), 32'd0);

    // Four requests answered empty.
    do_reset(1'b1);
    clear_ctrl();
    for (int i = 0; i < 4; i++) ctrl_step(1'b1, 1'b1, 2, 2, 100, 0);
    for (int i = 0; i < 8; i++) ctrl_step(1'b0, 1'b1, 2, 2, 100, 0);
    chk("empty_inflight", 32'(bus.inflight), 32'd0);
    chk("empty_count", 32'(bus.count), 32'd0);
    chk("empty_valid", 32'(bus.out_valid), 32'd0);
    chk("empty_err", 32'(bus.err), 32'd0);

    // Unsolicited response is still buffered and flags a sticky error.
    do_reset(1'b0);
    clear_ctrl();
    cycle(1'b0, 1'b1, 1'b0, 32'h55, 1'b0);
    chk("spur_err", 32'(bus.err), 32'd1);
    chk("spur_count", 32'(bus.count), 32'd1);
    chk("spur_addr", bus.out_buff_addr, 32'h55);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("spur_err_sticky", 32'(bus.err), 32'd1);

    // Reset with work in flight; the controller's late answers become errors.
    do_reset(1'b1);
    clear_ctrl();
    next_addr = 32'h2000;
    for (int i = 0; i < 8; i++) ctrl_step(1'b1, 1'b0, 3, 3, 0, 0);
    chk("midrst_count", 32'(bus.count), 32'd5);
    chk("midrst_inflight", 32'(bus.inflight), 32'd3);
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) ctrl_step(1'b0, 1'b0, 3, 3, 0, 0);
    chk("late_resp_err", 32'(bus.err), 32'd1);

    // Randomized legal traffic with changing consumer backpressure.
    do_reset(1'b1);
    clear_ctrl();
    bias = 60;
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0) bias = int'($urandom_range(95, 5));
      ctrl_step(int'($urandom_range(99)) < 85, int'($urandom_range(99)) < bias, 1, 6, 20, 0);
    end

    // Randomized traffic with occasional unsolicited responses.
    for (int i = 0; i < 500; i++) begin
      if (i % 100 == 0) bias = int'($urandom_range(95, 5));
      ctrl_step(int'($urandom_range(99)) < 85, int'($urandom_range(99)) < bias, 1, 6, 20, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
